// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences valid/ready read/write requests onto a single-port RAM.
// Define RAM_ACCESS_CTRL_INIT_EN to zero-fill the RAM after reset before accepting requests.
module ram_access_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [ADDR-1:0]  req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             ram_enable_o,
  output logic             ram_read_en_o,
  output logic [ADDR-1:0]  ram_address_o,
  output logic [WIDTH-1:0] ram_data_in_o,
  input  logic [WIDTH-1:0] ram_data_out_i,
  output logic             busy_o
);
`ifdef RAM_ACCESS_CTRL_INIT_EN
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, CAPTURE, RESP} state_t;
  localparam state_t RST_STATE = INIT;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  localparam logic RST_BUSY = (RST_STATE != IDLE);
  state_t           state_q;
  logic             en_q, rd_q, oob_q, ready_q, busy_q, rsp_valid_q;
  logic [ADDR-1:0]  addr_q;
  logic [WIDTH-1:0] din_q, rdata_q;
  logic             in_range;
  assign in_range = 32'(req_addr_i) < DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      en_q        <= 1'b0;
      rd_q        <= 1'b1;
      oob_q       <= 1'b0;
      ready_q     <= !RST_BUSY;
      busy_q      <= RST_BUSY;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
`ifdef RAM_ACCESS_CTRL_INIT_EN
        // en_q low marks the first INIT cycle; the fill starts on the next edge
        INIT: begin
          if (!en_q) begin
            en_q   <= 1'b1;
            rd_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
          end else if (addr_q == ADDR'(DEPTH - 1)) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            rd_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
`endif
        IDLE: if (req_valid_i && ready_q) begin
          state_q <= req_write_i ? WRITE : READ;
          en_q    <= in_range;
          rd_q    <= !req_write_i;
          oob_q   <= !in_range;
          addr_q  <= req_addr_i;
          din_q   <= req_write_i ? req_wdata_i : din_q;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        WRITE: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          rd_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        READ: begin
          state_q <= CAPTURE;
          en_q    <= 1'b0;
        end
        CAPTURE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rdata_q     <= oob_q ? '0 : ram_data_out_i;
        end
        RESP: if (rsp_ready_i) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= RST_STATE;
      endcase
    end
  end
  assign ram_enable_o  = en_q & !rst;
  assign ram_read_en_o = rd_q;
  assign ram_address_o = addr_q;
  assign ram_data_in_o = din_q;
  assign req_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench with an attached RAM and a transaction-level reference model.
module tb_ram_access_ctrl;
  localparam int W = 8, D = 16, A = 4;
`ifdef RAM_ACCESS_CTRL_INIT_EN
  localparam bit INITC = 1'b1;
`else
  localparam bit INITC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [A-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, ram_enable, ram_read_en, busy;
  logic [W-1:0] rsp_rdata, ram_data_in, ram_data_out;
  logic [A-1:0] ram_address;
  logic [W-1:0] mem [D];
  logic [D-1:0] zmask = '0;
  int total = 0, bad = 0, cyc = 0;
  int n, acc, prev, hs;

  ram_access_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .ram_enable_o(ram_enable), .ram_read_en_o(ram_read_en), .ram_address_o(ram_address),
    .ram_data_in_o(ram_data_in), .ram_data_out_i(ram_data_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // RAM: preset with 0x50+i so untouched locations have known contents
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < D; i++) mem[i] <= 8'(80 + i);
    end else if (ram_enable) begin
      if (ram_read_en) ram_data_out <= mem[ram_address];
      else begin
        mem[ram_address] <= ram_data_in;
        if (ram_data_in == '0) zmask[ram_address] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: shadow memory, next-ready cycle and one outstanding response
  logic [W-1:0] ref_mem [D];
  int ready_from, rsp_from;
  bit pend = 0, pw = 0, e_ready, e_valid;
  logic [A-1:0] pw_a;
  logic [W-1:0] pw_d, rsp_d, last_rd;
  initial begin
    for (int i = 0; i < D; i++) ref_mem[i] = 8'(80 + i);
    ready_from = INITC ? D + 2 : 1;
    last_rd = '0;
    forever begin
      @(negedge clk);
      if (pend && cyc >= rsp_from) last_rd = rsp_d;
      e_ready = cyc >= ready_from;
      e_valid = pend && cyc >= rsp_from;
      chk("m_req_ready", req_ready, e_ready);
      chk("m_busy", busy, !e_ready);
      chk("m_rsp_valid", rsp_valid, e_valid);
      chk("m_rsp_rdata", rsp_rdata, last_rd);
      if (rst) chk("m_enable_in_reset", ram_enable, 0);
      if (pw) begin
        if (!rst) ref_mem[pw_a] = pw_d;
        pw = 0;
      end
      if (rst) begin
        pend = 0;
        last_rd = '0;
        ready_from = INITC ? cyc + 2 + D : cyc + 1;
        if (INITC) for (int i = 0; i < D; i++) ref_mem[i] = '0;
      end else if (e_ready && req_valid) begin
        if (req_write) begin
          pw = 1; pw_a = req_addr; pw_d = req_wdata;
          ready_from = cyc + 2;
        end else begin
          pend = 1; rsp_d = ref_mem[req_addr];
          rsp_from = cyc + 3;
          ready_from = 1 << 30;
        end
      end else if (e_valid && rsp_ready) begin
        pend = 0;
        ready_from = cyc + 1;
      end
    end
  end

  task automatic wait_ready(input string nm);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin k++; @(negedge clk); end
    chk(nm, k < 50, 1);
  endtask

  task automatic settle(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin cnt++; @(negedge clk); end
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_addr = a; req_wdata = d;
    wait_ready("wr_accept");
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic do_read(input logic [A-1:0] a, input logic [W-1:0] exp);
    int k = 0, t;
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_addr = a; rsp_ready = 1;
    wait_ready("rd_accept");
    @(posedge clk); #1 req_valid = 0; t = cyc;
    @(negedge clk);
    while (!rsp_valid && k < 50) begin k++; @(negedge clk); end
    chk("rd_latency", cyc - t, 2);
    chk("rd_data", rsp_rdata, exp);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_drained", rsp_valid, 0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, req_ready, !INITC);
    chk({p, "_busy"}, busy, INITC);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_rdata"}, rsp_rdata, 0);
    chk({p, "_enable"}, ram_enable, 0);
    chk({p, "_read_en"}, ram_read_en, 1);
    chk({p, "_address"}, ram_address, 0);
    chk({p, "_data_in"}, ram_data_in, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1 rst = 0;
    @(posedge clk);
    settle(n);
    chk("init_busy_cycles", n, INITC ? D : 0);
    chk("init_zero_mask", zmask, INITC ? 16'hFFFF : 16'h0000);

    do_write(0, 8'hAB);
    do_write(1, 8'h56);
    do_write(2, 8'h9B);
    do_read(0, 8'hAB);
    do_read(1, 8'h56);
    do_read(2, 8'h9B);

    // response backpressure with a write waiting behind it
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_addr = 0; rsp_ready = 0;
    wait_ready("bp_accept");
    @(posedge clk); #1 acc = cyc;
    req_write = 1; req_addr = 3; req_wdata = 8'h11;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
    chk("bp_latency", cyc - acc, 2);
    chk("bp_data", rsp_rdata, 8'hAB);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_rdata, 8'hAB);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1 hs = cyc;
    wait_ready("bp_wr_accept");
    @(posedge clk); #1 acc = cyc; req_valid = 0;
    chk("bp_accept_gap", acc - hs, 1);
    do_read(3, 8'h11);

    // back-to-back writes with req_valid held high
    @(posedge clk); #1 req_valid = 1; req_write = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      req_addr = 4'(8 + k); req_wdata = 8'(8'hC0 + k);
      wait_ready("b2b_accept");
      @(posedge clk); #1 acc = cyc;
      if (k > 0) chk("b2b_gap", acc - prev, 2);
      prev = acc;
    end
    req_valid = 0;
    do_read(8, 8'hC0);
    do_read(11, 8'hC3);

    // reset during the WRITE cycle of 0x77@5
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_addr = 5; req_wdata = 8'h77;
    wait_ready("rstw_accept");
    @(posedge clk); #1 req_valid = 0; rst = 1;
    @(negedge clk);
    chk("rstw_enable", ram_enable, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk);
    settle(n);
    do_read(5, INITC ? 8'h00 : 8'h55);

    // reset and request handshake on the same edge
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_addr = 6; req_wdata = 8'h3C; rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("sim");
    @(posedge clk); #1 req_valid = 0; rst = 0;
    @(posedge clk);
    settle(n);
    do_read(6, INITC ? 8'h00 : 8'h56);
    do_read(15, INITC ? 8'h00 : 8'h5F);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request-side controller that sits directly upstream of the single-port RAM (`clk`, `enable`, `read_en`, `address`, `data_in`, `data_out`) and is its only driver. It accepts read/write requests on a valid/ready handshake and sequences the RAM's one shared port, one access at a time. It returns read data on a valid/ready response channel that holds its data until accepted. An optional post-reset zero-fill pass clears the RAM before the first request.

## Interface

- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 16, number of RAM locations.
- `ADDR`, `$clog2(DEPTH)`, address width in bits.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR  target location.
- `req_wdata`  in  WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer accepts read data.
- `rsp_rdata`  out  WIDTH  read data.
- `ram_enable`  out  1  drives RAM `enable`.
- `ram_read_en`  out  1  drives RAM `read_en`: 1 = read, 0 = write.
- `ram_address`  out  ADDR  drives RAM `address`.
- `ram_data_in`  out  WIDTH  drives RAM `data_in`.
- `ram_data_out`  in  WIDTH  from RAM `data_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation

RAM contract:
- The RAM writes `data_in` on a rising edge where `enable`=1 and `read_en`=0.
- The RAM registers `data_out` on a rising edge where `enable`=1 and `read_en`=1.

State machine (states INIT, IDLE, WRITE, READ, CAPTURE, RESP):
- **INIT**: present only with the configuration macro; see Configuration.
- **IDLE**: `req_ready`=1. A handshake (`req_valid` & `req_ready`) latches `req_write`, `req_addr` and `req_wdata`, then moves to WRITE or READ.
- **WRITE**: `ram_enable`=1, `ram_read_en`=0, with the latched address and data. The next state is IDLE.
- **READ**: `ram_enable`=1, `ram_read_en`=1, with the latched address. The next state is CAPTURE.
- **CAPTURE**: `ram_enable`=0. At the closing edge, `rsp_rdata` <= `ram_data_out` and `rsp_valid` <= 1. The next state is RESP.
- **RESP**: `rsp_valid`=1 and `rsp_rdata` is stable. On an edge with `rsp_ready`=1, `rsp_valid` <= 0 and the next state is IDLE.

Output behaviour:
- Outside WRITE, READ and INIT: `ram_enable`=0 and `ram_read_en`=1.
- `ram_address` and `ram_data_in` hold their last values outside active states.
- `ram_enable` is gated combinationally by `!rst`, so no RAM access occurs on any edge where `rst`=1.

Boundary rules:
- Out of range (`req_addr` >= `DEPTH`, only possible when `DEPTH` is not a power of 2): the request is accepted and the RAM is not accessed.
  - A write is dropped.
  - A read still passes through READ/CAPTURE timing with `ram_enable`=0 and returns `rsp_rdata`=0.
- `req_ready` is 0 in every state except IDLE. Requests stall there and are never lost.
- Reset mid-operation: a pending write is not committed, a pending response is discarded, and the FSM returns to its reset state.

## Timing

- Reset values:
  - `req_ready`=0 with the macro defined; 1 without it.
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=1 with the macro, 0 without it.
  - `ram_enable`=0, `ram_read_en`=1, `ram_address`=0, `ram_data_in`=0.
- Write: request accepted at edge E0. The WRITE cycle runs E0–E1, and the RAM writes at E1. `req_ready`=1 again after E1, so at most one write every 2 cycles.
- Read: request accepted at E0. READ runs E0–E1, and the RAM registers data at E1. CAPTURE runs E1–E2, and `rsp_valid`=1 after E2.
  - Accept-to-`rsp_valid` latency is exactly 2 cycles.
  - With `rsp_ready` held at 1, the next request is accepted at E4 at the earliest.
- `rsp_ready` is ignored while `rsp_valid`=0.

## Configuration

- Macro: `RAM_ACCESS_CTRL_INIT_EN`.
- Defined: reset enters INIT. After `rst` deasserts, INIT writes 0 to addresses 0..`DEPTH`-1, one address per cycle (`ram_enable`=1, `ram_read_en`=0, `ram_data_in`=0, address counter increments). It enters IDLE after the edge that writes `DEPTH`-1. `busy`=1 and `req_ready`=0 for exactly `DEPTH` cycles after the first edge with `rst`=0.
- Not defined: there is no INIT state, reset enters IDLE, and RAM contents are undefined until written.

## Test plan

- Writes then reads: write 0xAB@0, 0x56@1, 0x9B@2, then read 0, 1 and 2 with `rsp_ready`=1. Required: `rsp_rdata` = 0xAB, 0x56, 0x9B, each arriving 2 cycles after acceptance.
- Response backpressure: read 0xAB@0 with `rsp_ready`=0 for 5 cycles. Required: `rsp_valid`=1 and `rsp_rdata`=0xAB held stable, `req_ready`=0, and a request presented meanwhile is accepted only after `rsp_ready`=1.
- Reset mid-write: assert `rst` during the WRITE cycle of 0x77@5, then read 5. Required: `ram_enable`=0 on the reset edge, and location 5 keeps its prior value (0 with the macro).
- Back-to-back writes: hold `req_valid` high for 4 write requests. Required: `req_ready` toggles 1/0 and each write is accepted every 2 cycles.
- With `RAM_ACCESS_CTRL_INIT_EN`: release reset. Required: `busy`=1 for exactly 16 cycles, addresses 0..15 are written with 0, and a read of 15 afterwards returns 0x00.
- Simultaneous events: `rst` and a `req_valid` handshake on the same edge. Required: the request is not latched, and all outputs take their reset values.
